// File: rtl/ysyx_22040125_lsu_pkg.sv
// Shared constants and types for the load/store unit.
package ysyx_22040125_lsu_pkg;

    // RV64 load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Response error codes
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

    // One-hot load controls toward the data RAM; all zero means ld
    localparam logic [5:0] L_LB  = 6'b100000;
    localparam logic [5:0] L_LBU = 6'b010000;
    localparam logic [5:0] L_LH  = 6'b001000;
    localparam logic [5:0] L_LHU = 6'b000100;
    localparam logic [5:0] L_LW  = 6'b000010;
    localparam logic [5:0] L_LWU = 6'b000001;
    localparam logic [5:0] L_LD  = 6'b000000;

    // One-hot store controls toward the data RAM; all zero means sd
    localparam logic [2:0] S_SB = 3'b100;
    localparam logic [2:0] S_SH = 3'b010;
    localparam logic [2:0] S_SW = 3'b001;
    localparam logic [2:0] S_SD = 3'b000;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/ysyx_22040125_lsu_decode.sv
// Combinational decode of an LSU op into RAM size controls and an error code.
// Size controls are forced to zero whenever the op faults.
module ysyx_22040125_lsu_decode
    import ysyx_22040125_lsu_pkg::*;
(
    input  logic       load,
    input  logic       store,
    input  logic [2:0] funct3,
    input  logic [2:0] addr_lo,
    output logic [5:0] l_bhw,
    output logic [2:0] s_bhwd,
    output logic [1:0] err
);

    logic illegal;
    logic misalign;
    logic [5:0] l_raw;
    logic [2:0] s_raw;

    // Decode funct3 and alignment; illegal wins over misaligned
    always_comb begin
        l_raw    = L_LD;
        s_raw    = S_SD;
        illegal  = 1'b0;
        misalign = 1'b0;
        if (load == store) begin
            illegal = 1'b1;
        end else if (load) begin
            case (funct3)
                F3_B:  l_raw = L_LB;
                F3_BU: l_raw = L_LBU;
                F3_H: begin
                    l_raw    = L_LH;
                    misalign = addr_lo[0];
                end
                F3_HU: begin
                    l_raw    = L_LHU;
                    misalign = addr_lo[0];
                end
                F3_W: begin
                    l_raw    = L_LW;
                    misalign = (addr_lo[1:0] != 2'b00);
                end
                F3_WU: begin
                    l_raw    = L_LWU;
                    misalign = (addr_lo[1:0] != 2'b00);
                end
                F3_D: begin
                    l_raw    = L_LD;
                    misalign = (addr_lo != 3'b000);
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B: s_raw = S_SB;
                F3_H: begin
                    s_raw    = S_SH;
                    misalign = addr_lo[0];
                end
                F3_W: begin
                    s_raw    = S_SW;
                    misalign = (addr_lo[1:0] != 2'b00);
                end
                F3_D: begin
                    s_raw    = S_SD;
                    misalign = (addr_lo != 3'b000);
                end
                default: illegal = 1'b1;
            endcase
        end

        if (illegal) begin
            err    = ERR_ILLEGAL;
            l_bhw  = 6'b0;
            s_bhwd = 3'b0;
        end else if (misalign) begin
            err    = ERR_MISALIGN;
            l_bhw  = 6'b0;
            s_bhwd = 3'b0;
        end else begin
            err    = ERR_OK;
            l_bhw  = load  ? l_raw : 6'b0;
            s_bhwd = store ? s_raw : 3'b0;
        end
    end

endmodule

// File: rtl/ysyx_22040125_lsu.sv
// Load/store unit: one op per req handshake, RAM controls driven in the
// accept cycle, response held in RESP until writeback takes it.
module ysyx_22040125_lsu
    import ysyx_22040125_lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_load,
    input  logic          req_store,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [4:0]    req_rd,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic [4:0]    resp_rd,
    output logic          resp_wb,
    output logic [1:0]    resp_err,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic [5:0]    ram_l_bhw,
    output logic [2:0]    ram_s_bhwd,
    output logic          ram_wen,
    output logic          ram_ren,
    input  logic [DW-1:0] ram_rdata
);

    lsu_state_e state_q;
    lsu_state_e state_d;

    logic [5:0] dec_l_bhw;
    logic [2:0] dec_s_bhwd;
    logic [1:0] dec_err;
    logic       dec_ok;
    logic       acc;

    logic [4:0] rd_p1;
    logic [1:0] err_p1;
    logic       load_p1;
    logic       wb_p1;

    ysyx_22040125_lsu_decode u_decode (
        .load    (req_load),
        .store   (req_store),
        .funct3  (req_funct3),
        .addr_lo (req_addr[2:0]),
        .l_bhw   (dec_l_bhw),
        .s_bhwd  (dec_s_bhwd),
        .err     (dec_err)
    );

    assign dec_ok    = (dec_err == ERR_OK);
    assign req_ready = ~rst & ((state_q == IDLE) | ((state_q == RESP) & resp_ready));
    assign acc       = req_valid & req_ready;

    // RAM controls come straight from the request so the RAM samples them at the accept edge
    always_comb begin
        ram_addr   = req_addr;
        ram_wdata  = req_wdata;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        ram_l_bhw  = 6'b0;
        ram_s_bhwd = 3'b0;
        if (acc && dec_ok) begin
            ram_ren    = req_load;
            ram_wen    = req_store;
            ram_l_bhw  = dec_l_bhw;
            ram_s_bhwd = dec_s_bhwd;
        end
    end

    // Next state: enter or stay in RESP on accept, drain to IDLE once the response is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (acc) state_d = RESP;
            RESP: if (resp_ready) state_d = acc ? RESP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and response metadata; reset drops any pending response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rd_p1   <= 5'd0;
            err_p1  <= ERR_OK;
            load_p1 <= 1'b0;
            wb_p1   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                rd_p1   <= req_rd;
                err_p1  <= dec_err;
                load_p1 <= req_load & ~req_store;
                wb_p1   <= req_load & dec_ok;
            end
        end
    end

    // ---- response stage: RAM holds its read data, so it is forwarded, not stored
    assign resp_valid = (state_q == RESP);
    assign resp_rd    = rd_p1;
    assign resp_err   = err_p1;
    assign resp_wb    = wb_p1;
    assign resp_data  = (resp_valid && load_p1 && (err_p1 == ERR_OK)) ? ram_rdata : '0;

endmodule

// File: tb/tb_ysyx_22040125_lsu.sv
// Directed bench for the LSU with a behavioural byte-lane RAM model.
module tb_ysyx_22040125_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_ready, resp_wb;
    logic [63:0] resp_data;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_err;
    logic [31:0] ram_addr;
    logic [63:0] ram_wdata, ram_rdata;
    logic [5:0]  ram_l_bhw;
    logic [2:0]  ram_s_bhwd;
    logic        ram_wen, ram_ren;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22040125_lsu #(.AW(32), .DW(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_wb(resp_wb), .resp_err(resp_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_l_bhw(ram_l_bhw),
        .ram_s_bhwd(ram_s_bhwd), .ram_wen(ram_wen), .ram_ren(ram_ren),
        .ram_rdata(ram_rdata)
    );

    // Behavioural RAM: registered, sign/zero-extended reads and lane writes
    logic [63:0] mem [256];

    function automatic logic [63:0] ram_read(input logic [2:0] lo, input logic [5:0] lb, input logic [63:0] w);
        logic [63:0] s;
        s = w >> {lo, 3'b000};
        case (lb)
            6'b100000: return {{56{s[7]}}, s[7:0]};
            6'b010000: return {56'd0, s[7:0]};
            6'b001000: return {{48{s[15]}}, s[15:0]};
            6'b000100: return {48'd0, s[15:0]};
            6'b000010: return {{32{s[31]}}, s[31:0]};
            6'b000001: return {32'd0, s[31:0]};
            default:   return w;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [63:0] m;
        if (ram_ren) ram_rdata <= ram_read(ram_addr[2:0], ram_l_bhw, mem[ram_addr[10:3]]);
        if (ram_wen) begin
            case (ram_s_bhwd)
                3'b100:  m = 64'hFF << {ram_addr[2:0], 3'b000};
                3'b010:  m = 64'hFFFF << {ram_addr[2:0], 3'b000};
                3'b001:  m = 64'hFFFF_FFFF << {ram_addr[2:0], 3'b000};
                default: m = '1;
            endcase
            mem[ram_addr[10:3]] <= (mem[ram_addr[10:3]] & ~m) | ((ram_wdata << {ram_addr[2:0], 3'b000}) & m);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        ren;
        logic        wen;
        logic [5:0]  lbhw;
        logic [2:0]  sbhwd;
        logic [63:0] data;
        logic        wb;
        logic [1:0]  err;
    } vec_t;

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [63:0] wdata, input logic ren, input logic wen, input logic [5:0] lbhw,
                                input logic [2:0] sbhwd, input logic [63:0] data, input logic wb, input logic [1:0] err);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.ren = ren; v.wen = wen;
        v.lbhw = lbhw; v.sbhwd = sbhwd; v.data = data; v.wb = wb; v.err = err;
        return v;
    endfunction

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [4:0] rd);
        req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
    endtask

    // Single op from IDLE: check strobes in the accept cycle, response the next cycle
    task automatic do_op(input string tag, input vec_t v, input logic [4:0] rd);
        @(negedge clk);
        drive(v.ld, v.st, v.f3, v.addr, v.wdata, rd);
        resp_ready = 1'b1;
        #1;
        chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, ".ren"},   64'(ram_ren),    64'(v.ren));
        chk({tag, ".wen"},   64'(ram_wen),    64'(v.wen));
        chk({tag, ".lbhw"},  64'(ram_l_bhw),  64'(v.lbhw));
        chk({tag, ".sbhwd"}, 64'(ram_s_bhwd), 64'(v.sbhwd));
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        chk({tag, ".resp_valid"}, 64'(resp_valid), 64'd1);
        chk({tag, ".resp_data"},  resp_data,       v.data);
        chk({tag, ".resp_wb"},    64'(resp_wb),    64'(v.wb));
        chk({tag, ".resp_err"},   64'(resp_err),   64'(v.err));
        chk({tag, ".resp_rd"},    64'(resp_rd),    64'(rd));
        chk({tag, ".strobes_idle"}, 64'({ram_ren, ram_wen}), 64'd0);
        @(posedge clk); #1;
        chk({tag, ".drained"}, 64'(resp_valid), 64'd0);
    endtask

    vec_t vecs[20];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'd0;
        mem[9'h000] = 64'hFFFF_FFFF_8000_0001;
        ram_rdata = 64'd0;

        //           ld st  f3      addr          wdata                   ren wen lbhw       sbhwd   data                     wb err
        vecs[0]  = mk(1, 0, 3'b010, 32'h1000, 64'd0,                  1, 0, 6'b000010, 3'b000, 64'hFFFF_FFFF_8000_0001, 1, 2'b00);
        vecs[1]  = mk(0, 1, 3'b000, 32'h1003, 64'hAB,                 0, 1, 6'b000000, 3'b100, 64'd0,                   0, 2'b00);
        vecs[2]  = mk(1, 0, 3'b100, 32'h1003, 64'd0,                  1, 0, 6'b010000, 3'b000, 64'h0000_0000_0000_00AB, 1, 2'b00);
        vecs[3]  = mk(1, 0, 3'b001, 32'h1001, 64'd0,                  0, 0, 6'b000000, 3'b000, 64'd0,                   0, 2'b01);
        vecs[4]  = mk(1, 0, 3'b111, 32'h1000, 64'd0,                  0, 0, 6'b000000, 3'b000, 64'd0,                   0, 2'b10);
        vecs[5]  = mk(1, 1, 3'b000, 32'h1000, 64'h77,                 0, 0, 6'b000000, 3'b000, 64'd0,                   0, 2'b10);
        vecs[6]  = mk(0, 0, 3'b000, 32'h1000, 64'd0,                  0, 0, 6'b000000, 3'b000, 64'd0,                   0, 2'b10);
        vecs[7]  = mk(0, 1, 3'b100, 32'h1000, 64'h99,                 0, 0, 6'b000000, 3'b000, 64'd0,                   0, 2'b10);
        vecs[8]  = mk(1, 0, 3'b000, 32'h1003, 64'd0,                  1, 0, 6'b100000, 3'b000, 64'hFFFF_FFFF_FFFF_FFAB, 1, 2'b00);
        vecs[9]  = mk(0, 1, 3'b011, 32'h1008, 64'h1122_3344_5566_7788, 0, 1, 6'b000000, 3'b000, 64'd0,                  0, 2'b00);
        vecs[10] = mk(1, 0, 3'b011, 32'h1008, 64'd0,                  1, 0, 6'b000000, 3'b000, 64'h1122_3344_5566_7788, 1, 2'b00);
        vecs[11] = mk(1, 0, 3'b110, 32'h1000, 64'd0,                  1, 0, 6'b000001, 3'b000, 64'h0000_0000_AB00_0001, 1, 2'b00);
        vecs[12] = mk(1, 0, 3'b101, 32'h100A, 64'd0,                  1, 0, 6'b000100, 3'b000, 64'h0000_0000_0000_5566, 1, 2'b00);
        vecs[13] = mk(0, 1, 3'b001, 32'h1010, 64'hFFFF_8765,          0, 1, 6'b000000, 3'b010, 64'd0,                   0, 2'b00);
        vecs[14] = mk(1, 0, 3'b001, 32'h1010, 64'd0,                  1, 0, 6'b001000, 3'b000, 64'hFFFF_FFFF_FFFF_8765, 1, 2'b00);
        vecs[15] = mk(0, 1, 3'b010, 32'h1005, 64'h1,                  0, 0, 6'b000000, 3'b000, 64'd0,                   0, 2'b01);
        vecs[16] = mk(1, 0, 3'b011, 32'h1004, 64'd0,                  0, 0, 6'b000000, 3'b000, 64'd0,                   0, 2'b01);
        vecs[17] = mk(1, 0, 3'b010, 32'h1006, 64'd0,                  0, 0, 6'b000000, 3'b000, 64'd0,                   0, 2'b01);
        vecs[18] = mk(0, 1, 3'b011, 32'h1009, 64'h2,                  0, 0, 6'b000000, 3'b000, 64'd0,                   0, 2'b01);
        vecs[19] = mk(0, 1, 3'b111, 32'h1003, 64'h3,                  0, 0, 6'b000000, 3'b000, 64'd0,                   0, 2'b10);

        rst = 1'b1; resp_ready = 1'b0;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 64'd0; req_rd = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.resp_valid", 64'(resp_valid), 64'd0);
        chk("reset.resp_wb",    64'(resp_wb),    64'd0);
        chk("reset.resp_rd",    64'(resp_rd),    64'd0);
        chk("reset.resp_err",   64'(resp_err),   64'd0);
        chk("reset.req_ready",  64'(req_ready),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.req_ready_after", 64'(req_ready), 64'd1);

        for (int i = 0; i < 20; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i], 5'(i + 1));
        end

        // Stall an ld for 3 cycles, then a queued sd and ld go through back-to-back
        @(negedge clk);
        drive(1, 0, 3'b011, 32'h1008, 64'd0, 5'd7);
        resp_ready = 1'b0;
        @(posedge clk); #1;
        drive(0, 1, 3'b011, 32'h1018, 64'hDEAD_BEEF_CAFE_F00D, 5'd8);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall.resp_valid", 64'(resp_valid), 64'd1);
            chk("stall.resp_data",  resp_data,       64'h1122_3344_5566_7788);
            chk("stall.resp_rd",    64'(resp_rd),    64'd7);
            chk("stall.resp_wb",    64'(resp_wb),    64'd1);
            chk("stall.req_ready",  64'(req_ready),  64'd0);
            chk("stall.strobes",    64'({ram_ren, ram_wen}), 64'd0);
        end
        resp_ready = 1'b1;
        #1;
        chk("b2b.sd_req_ready", 64'(req_ready), 64'd1);
        chk("b2b.sd_wen",       64'(ram_wen),   64'd1);
        chk("b2b.sd_sbhwd",     64'(ram_s_bhwd), 64'd0);
        chk("b2b.ld_data_held", resp_data,      64'h1122_3344_5566_7788);
        @(posedge clk); #1;
        drive(1, 0, 3'b011, 32'h1018, 64'd0, 5'd9);
        #1;
        chk("b2b.sd_resp_valid", 64'(resp_valid), 64'd1);
        chk("b2b.sd_resp_rd",    64'(resp_rd),    64'd8);
        chk("b2b.sd_resp_wb",    64'(resp_wb),    64'd0);
        chk("b2b.sd_resp_data",  resp_data,       64'd0);
        chk("b2b.ld_ren",        64'(ram_ren),    64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        chk("b2b.ld_resp_valid", 64'(resp_valid), 64'd1);
        chk("b2b.ld_resp_rd",    64'(resp_rd),    64'd9);
        chk("b2b.ld_resp_data",  resp_data,       64'hDEAD_BEEF_CAFE_F00D);
        chk("b2b.ld_resp_wb",    64'(resp_wb),    64'd1);
        @(posedge clk); #1;
        chk("b2b.drained", 64'(resp_valid), 64'd0);

        // Reset while a response is pending and a store is presented
        @(negedge clk);
        drive(1, 0, 3'b010, 32'h1000, 64'd0, 5'd10);
        resp_ready = 1'b0;
        @(posedge clk); #1;
        drive(0, 1, 3'b000, 32'h1020, 64'h55, 5'd11);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid.wen",       64'(ram_wen),   64'd0);
        chk("rstmid.req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rstmid.resp_valid", 64'(resp_valid), 64'd0);
        chk("rstmid.req_ready",  64'(req_ready),  64'd1);
        chk("rstmid.resp_wb",    64'(resp_wb),    64'd0);
        chk("rstmid.resp_rd",    64'(resp_rd),    64'd0);
        do_op("rstmid.readback", mk(1, 0, 3'b100, 32'h1020, 64'd0, 1, 0, 6'b010000, 3'b000, 64'd0, 1, 2'b00), 5'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
